// File: rtl/conv1d_result_writer_if.sv
// Stream-in / SRAM-out bundle for the conv1d result writer.
// master = the writer itself, slave = the surrounding accelerator and memory.
interface conv1d_result_writer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] num_results;
  logic             res_valid;
  logic [31:0]      res_data;
  logic             res_ready;
  logic             req_valid;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [3:0]       req_be;
  logic             req_we;
  logic             req_gnt;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] wr_count;
  logic             err;

  modport master (
    input  start, base_addr, num_results, res_valid, res_data, req_gnt,
    output res_ready, req_valid, req_addr, req_wdata, req_be, req_we,
           busy, done, wr_count, err
  );

  modport slave (
    output start, base_addr, num_results, res_valid, res_data, req_gnt,
    input  res_ready, req_valid, req_addr, req_wdata, req_be, req_we,
           busy, done, wr_count, err
  );
endinterface

// File: rtl/conv1d_result_writer.sv
// Buffers finished conv1d results in a small FIFO and writes them as
// consecutive 32-bit words to SRAM over a request/grant handshake.
//
// state | meaning
// IDLE  | waiting for start; results arriving here are dropped and flag err
// RUN   | accepting results into the FIFO and issuing SRAM writes
// DONE  | single-cycle completion pulse, then back to IDLE
module conv1d_result_writer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  conv1d_result_writer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [31:0]      base_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] wr_cnt_inc;
  logic             err_q;

  logic [31:0]      fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fifo_cnt;

  logic             start_ok;
  logic             accepting;
  logic             push;
  logic             pop;
  logic             last_pop;

  assign start_ok   = (state == IDLE) && bus.start;
  assign accepting  = (state == RUN) && (acc_cnt < num_q);
  assign push       = bus.res_valid && bus.res_ready;
  assign pop        = bus.req_valid && bus.req_gnt;
  assign wr_cnt_inc = wr_cnt + CNT_W'(1);
  assign last_pop   = pop && (wr_cnt_inc == num_q);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.num_results == '0) ? DONE : RUN;
      RUN:  if (last_pop)  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend on registered state only, never on req_gnt.
  always_comb begin
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      RUN: begin
        bus.busy      = 1'b1;
        bus.res_ready = (fifo_cnt < FULL) && (acc_cnt < num_q);
        bus.req_valid = (fifo_cnt != '0);
      end
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  // Address and data are parked at zero whenever no request is pending.
  assign bus.req_addr  = bus.req_valid ? (base_q + 32'({wr_cnt, 2'b00})) : 32'h0;
  assign bus.req_wdata = bus.req_valid ? fifo_mem[rd_ptr] : 32'h0;
  assign bus.req_be    = 4'hF;
  assign bus.req_we    = bus.req_valid;
  assign bus.wr_count  = wr_cnt;
  assign bus.err       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q   <= '0;
      num_q    <= '0;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      err_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (start_ok) begin
        base_q  <= bus.base_addr & 32'hFFFF_FFFC;
        num_q   <= bus.num_results;
        acc_cnt <= '0;
        wr_cnt  <= '0;
        err_q   <= 1'b0;
      end
      // A stray result in the same cycle as start still counts as an error.
      if (bus.res_valid && !accepting) err_q <= 1'b1;
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        wr_cnt <= wr_cnt_inc;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.res_data;
  end
endmodule
